// File: rtl/axi_slave_write_ctrl.sv
// axi_slave_write_ctrl
//   Write-transaction controller for the generic AXI3 slave memory.
//   It accepts one AW command, then counts W beats against awlen. It generates
//   a word address for each beat of a FIXED, INCR or WRAP burst and drives a
//   registered write port into the memory array. It returns one B response
//   per burst. The handshake order is AW -> W -> B, with one transaction
//   outstanding at a time.
//
//   Optional build macro: AXI_WID_CHECK_EN
//     defined   : each beat's wid is compared with the latched awid; on a
//                 mismatch the beat is dropped and the burst reports SLVERR
//     undefined : wid is ignored
//
// Ports
//   aclk, aresetn              clock, asynchronous active-low reset
//   aw*  (awid .. awready)     write address channel
//   w*   (wid .. wready)       write data channel
//   b*   (bid .. bready)       write response channel
//   mem_we/addr/wdata/wstrb    registered memory write port, 1-cycle latency
module axi_slave_write_ctrl #(
  parameter int unsigned MEM_AW    = 7,
  parameter int unsigned MEM_DEPTH = 128
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        awid,
  input  logic [31:0]       awadr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wrdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;
  typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [3:0]        id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic              err_q, err_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [3:0]        bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;

  // Per-beat address arithmetic
  logic [31:0] incr;
  logic [31:0] wrap_mask;
  logic [31:0] addr_inc;
  logic        out_of_range;
  logic        suppress;
  logic        len_hit;
  logic        wrap_len_ok;
  logic        beat;

  assign incr         = 32'(1) << size_q;
  assign wrap_mask    = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
  assign addr_inc     = addr_q + incr;
  assign out_of_range = {2'b00, addr_q[31:2]} >= 32'(MEM_DEPTH);
  assign len_hit      = (beat_cnt_q == len_q);
  assign wrap_len_ok  = (awlen == 4'd1) || (awlen == 4'd3) ||
                        (awlen == 4'd7) || (awlen == 4'd15);
  assign beat         = wvalid & wready_q;

`ifdef AXI_WID_CHECK_EN
  assign suppress = (size_q > 3'd2) | out_of_range | (wid != id_q);
`else
  // wid has no function in this build
  logic unused_wid;
  assign unused_wid = ^wid;
  assign suppress   = (size_q > 3'd2) | out_of_range;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      S_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b0;
        if (awvalid && awready_q) begin
          id_d       = awid;
          addr_d     = awadr;
          len_d      = awlen;
          size_d     = awsize;
          beat_cnt_d = 4'd0;
          // Reserved and badly sized WRAP bursts run as INCR but report SLVERR
          err_d      = (awburst == 2'b11) || ((awburst == 2'b10) && !wrap_len_ok);
          if (awburst == 2'b00)
            mode_d = M_FIXED;
          else if ((awburst == 2'b10) && wrap_len_ok)
            mode_d = M_WRAP;
          else
            mode_d = M_INCR;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        if (beat) begin
          mem_we_d    = !suppress;
          mem_addr_d  = addr_q[MEM_AW+1:2];
          mem_wdata_d = wrdata;
          mem_wstrb_d = wstrb;
          err_d       = err_q | suppress | (wlast != len_hit);
          beat_cnt_d  = beat_cnt_q + 4'd1;
          case (mode_q)
            M_FIXED: addr_d = addr_q;
            M_WRAP:  addr_d = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default: addr_d = addr_inc;
          endcase
          // The burst ends at wlast or at awlen, whichever is first
          if (wlast || len_hit) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_d ? 2'b10 : 2'b00;
            state_d  = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      mode_q      <= M_FIXED;
      id_q        <= 4'd0;
      addr_q      <= 32'd0;
      len_q       <= 4'd0;
      size_q      <= 3'd0;
      beat_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= 4'd0;
      bresp_q     <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_axi_slave_write_ctrl.sv
// Bench for axi_slave_write_ctrl. A reference model turns each burst into the
// memory writes and the B response it should produce, and queues them. A
// monitor compares these against the DUT outputs.
module tb_axi_slave_write_ctrl;
  localparam int unsigned MEM_AW    = 7;
  localparam int unsigned MEM_DEPTH = 128;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [3:0]        awid = '0;
  logic [31:0]       awadr = '0;
  logic [3:0]        awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awburst = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [3:0]        wid = '0;
  logic [31:0]       wrdata = '0;
  logic [3:0]        wstrb = '0;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [3:0]        bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  axi_slave_write_ctrl #(.MEM_AW(MEM_AW), .MEM_DEPTH(MEM_DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [6:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  int  checks = 0;
  int  passes = 0;
  logic [31:0] bd[16];
  logic [3:0]  bs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Monitor: every write or B handshake must match the head of its queue
  always @(negedge aclk) begin
    wr_t e;
    b_t  eb;
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) chk("unexpected_mem_we", 32'd1, 32'd0);
      else begin
        e = exp_wr.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", mem_wdata, e.data);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.strb));
      end
    end
    if (bvalid === 1'b1 && bready === 1'b1) begin
      if (exp_b.size() == 0) chk("unexpected_b", 32'd1, 32'd0);
      else begin
        eb = exp_b.pop_front();
        chk("bid", 32'(bid), 32'(eb.id));
        chk("bresp", 32'(bresp), 32'(eb.resp));
      end
    end
  end

  // Reference model: beat addresses come from plain modular arithmetic
  task automatic model_push(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int size, input int burst,
                            input int wl_pos);
    int nb;
    bit err, wrap;
    logic [31:0] sz, blk, base, a;
    wr_t w;
    b_t b;
    nb   = (wl_pos < len) ? wl_pos + 1 : len + 1;
    wrap = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
    err  = (burst == 3) || (burst == 2 && !wrap) || (wl_pos != len);
    sz   = 32'(1) << size;
    blk  = 32'(len + 1) * sz;
    base = addr - (addr % blk);
    for (int i = 0; i < nb; i++) begin
      if (burst == 0) a = addr;
      else if (wrap)  a = base + ((addr - base) + 32'(i) * sz) % blk;
      else            a = addr + 32'(i) * sz;
      if (size > 2 || (a >> 2) >= MEM_DEPTH) err = 1'b1;
      else begin
        w.addr = a[8:2]; w.data = bd[i]; w.strb = bs[i];
        exp_wr.push_back(w);
      end
    end
    b.id = id; b.resp = err ? 2'b10 : 2'b00;
    exp_b.push_back(b);
  endtask

  // Drivers start and end at 1 time unit after a rising edge
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                         input int len, input int size, input int burst);
    int n = 0;
    bit hs = 0;
    awid = id; awadr = addr; awlen = 4'(len); awsize = 3'(size);
    awburst = 2'(burst); awvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge aclk); hs = awready;
      @(posedge aclk); #1; n++;
    end
    awvalid = 1'b0;
    if (!hs) chk("awready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s,
                           input bit last, input logic [3:0] id, input bit gaps);
    int n = 0;
    bit hs = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    wid = id; wrdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge aclk); hs = wready;
      @(posedge aclk); #1; n++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (!hs) chk("wready_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv_b(input logic [3:0] id, input logic [1:0] resp, input int hold);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 50) begin
      @(negedge aclk); seen = bvalid;
      if (!seen) begin @(posedge aclk); #1; n++; end
    end
    if (!seen) begin
      chk("bvalid_timeout", 32'd0, 32'd1);
      @(posedge aclk); #1;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      chk("hold_bvalid", 32'(bvalid), 32'd1);
      chk("hold_bid", 32'(bid), 32'(id));
      chk("hold_bresp", 32'(bresp), 32'(resp));
      chk("hold_awready", 32'(awready), 32'd0);
      @(posedge aclk); #1; @(negedge aclk);
    end
    @(posedge aclk); #1; bready = 1'b1;
    @(posedge aclk); #1; bready = 1'b0;
    @(negedge aclk);
    chk("awready_after_b", 32'(awready), 32'd1);
    chk("bvalid_after_b", 32'(bvalid), 32'd0);
    @(posedge aclk); #1;
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                           input int len, input int size, input int burst,
                           input int wl_pos, input int hold, input bit rnd);
    int nb;
    b_t eb;
    for (int i = 0; i < 16; i++) begin
      bd[i] = $urandom();
      bs[i] = rnd ? 4'($urandom_range(0, 15)) : 4'hF;
    end
    model_push(id, addr, len, size, burst, wl_pos);
    eb = exp_b[$];
    nb = (wl_pos < len) ? wl_pos + 1 : len + 1;
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i < nb; i++) send_beat(bd[i], bs[i], i == wl_pos, id, rnd);
    recv_b(eb.id, eb.resp, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_awready", 32'(awready), 32'd0);
    chk("reset_bvalid", 32'(bvalid), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    aresetn = 1'b1;
    #1 chk("awready_before_edge", 32'(awready), 32'd0);
    @(posedge aclk); #1;
    chk("awready_first_edge", 32'(awready), 32'd1);

    // W beats before AW must be held off
    wvalid = 1'b1; wrdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    repeat (3) begin
      @(negedge aclk); chk("wready_idle", 32'(wready), 32'd0);
    end
    @(posedge aclk); #1; wvalid = 1'b0;

    run_burst(4'h3, 32'h10, 3, 2, 1, 3, 5, 1'b0);   // INCR, bready held low 5 cycles
    run_burst(4'h5, 32'h38, 3, 2, 2, 3, 0, 1'b0);   // WRAP -> 14,15,12,13
    run_burst(4'h6, 32'h20, 2, 2, 0, 2, 1, 1'b0);   // FIXED -> 8 x3
    run_burst(4'h7, 32'h00, 3, 2, 1, 1, 0, 1'b0);   // early wlast
    run_burst(4'h8, 32'h200, 0, 2, 1, 0, 0, 1'b0);  // word 128 out of range
    run_burst(4'h9, 32'h1FC, 1, 2, 1, 1, 0, 1'b0);  // crosses the top of memory
    run_burst(4'hA, 32'h40, 2, 2, 1, 16, 0, 1'b0);  // wlast missing
    run_burst(4'hB, 32'h40, 2, 2, 2, 2, 0, 1'b0);   // WRAP with bad length
    run_burst(4'hC, 32'h40, 1, 2, 3, 1, 0, 1'b0);   // reserved burst type
    run_burst(4'hD, 32'h40, 1, 3, 1, 1, 0, 1'b0);   // size > 2
    run_burst(4'hE, 32'h0, 15, 2, 1, 15, 0, 1'b0);  // 16-beat maximum

    // Reset in the middle of a 4-beat burst
    bd[0] = 32'hCAFE_0001; bs[0] = 4'hF;
    begin
      wr_t w;
      w.addr = 7'd16; w.data = bd[0]; w.strb = 4'hF;
      exp_wr.push_back(w);
    end
    send_aw(4'h2, 32'h40, 3, 2, 1);
    send_beat(bd[0], bs[0], 1'b0, 4'h2, 1'b0);
    @(negedge aclk); #2;
    aresetn = 1'b0;
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("awready_after_rst", 32'(awready), 32'd1);
    run_burst(4'h4, 32'h8, 0, 2, 1, 0, 0, 1'b0);

`ifdef AXI_WID_CHECK_EN
    // The first beat carries the wrong wid and is dropped
    begin
      wr_t w;
      b_t b;
      bd[0] = 32'h1111_1111; bd[1] = 32'h2222_2222;
      w.addr = 7'd21; w.data = bd[1]; w.strb = 4'hF;
      exp_wr.push_back(w);
      b.id = 4'h1; b.resp = 2'b10;
      exp_b.push_back(b);
      send_aw(4'h1, 32'h50, 1, 2, 1);
      send_beat(bd[0], 4'hF, 1'b0, 4'h2, 1'b0);
      send_beat(bd[1], 4'hF, 1'b1, 4'h1, 1'b0);
      recv_b(4'h1, 2'b10, 1);
    end
`endif

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      int len, size, burst, wl, r;
      logic [31:0] addr;
      len   = $urandom_range(0, 15);
      r     = $urandom_range(0, 9);
      size  = (r < 8) ? 2 : $urandom_range(0, 3);
      r     = $urandom_range(0, 9);
      burst = (r < 9) ? $urandom_range(0, 2) : 3;
      r     = $urandom_range(0, 9);
      addr  = (r < 8) ? 32'($urandom_range(0, 32'h1FF)) : 32'($urandom_range(32'h1C0, 32'h23F));
      addr  = addr & ~((32'(1) << size) - 32'd1);
      r     = $urandom_range(0, 9);
      wl    = (r < 8) ? len : ((r == 8) ? $urandom_range(0, len) : 16);
      run_burst(4'($urandom_range(0, 15)), addr, len, size, burst, wl,
                $urandom_range(0, 3), 1'b1);
    end

    repeat (4) @(posedge aclk);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_slave_write_ctrl.md
Name: axi_slave_write_ctrl

Overview:
Write-transaction controller for the generic AXI3 slave memory. Accepts one AW command at a time and counts W beats against awlen. Generates per-beat word addresses for FIXED, INCR and WRAP bursts, drives a registered write port into the slave memory array, and returns a single B response per burst. It replaces free-running awready/wready with a proper AW -> W -> B sequence.

Parameters:
MEM_AW, 7, word-address width of the memory port.
MEM_DEPTH, 128, number of 32-bit words; word index >= MEM_DEPTH is out of range.

Ports:
aclk  input  1  clock
aresetn  input  1  reset, asynchronous, active-low
awid  input  4  write address ID
awadr  input  32  write byte address
awlen  input  4  burst length minus one
awsize  input  3  beat size, log2 bytes
awburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  input  1  write address valid
awready  output  1  write address ready
wid  input  4  write data ID
wrdata  input  32  write data
wstrb  input  4  byte strobes
wlast  input  1  last beat
wvalid  input  1  write data valid
wready  output  1  write data ready
bid  output  4  response ID
bresp  output  2  00 OKAY, 10 SLVERR
bvalid  output  1  response valid
bready  input  1  response ready
mem_we  output  1  memory write enable, one-cycle pulse per accepted beat
mem_addr  output  MEM_AW  word address
mem_wdata  output  32  write data
mem_wstrb  output  4  byte enables

Behaviour:
- Reset (aresetn low, asynchronous): state IDLE; awready, wready, bvalid, mem_we = 0; bid, bresp, mem_addr, mem_wdata, mem_wstrb = 0; error flag cleared. Reset mid-burst abandons the burst; no B is issued.
- All outputs are registered. awready rises on the first aclk edge after reset release.
- IDLE: awready = 1, wready = 0.
  - On awvalid & awready: latch id, addr, len, size and burst; clear beat_cnt and error flag; go to DATA; awready = 0.
- DATA: wready = 1, awready = 0. Each wvalid & wready is one beat:
  - Next cycle: mem_we = 1, mem_addr = cur_addr[MEM_AW+1:2], mem_wdata = wrdata, mem_wstrb = wstrb (1-cycle latency).
  - Beat is suppressed (mem_we stays 0) and error flag is set if awsize > 2 or the word index >= MEM_DEPTH.
  - Address update per beat: FIXED none. INCR cur_addr += (1 << size). WRAP increments, then wraps within the aligned block of (len+1) << size bytes; low bits wrap, upper bits hold. Reserved 11 behaves as INCR and sets the error flag.
  - WRAP with len not in {1, 3, 7, 15} sets the error flag and behaves as INCR.
  - Burst ends on the beat where wlast = 1 OR beat_cnt == len, whichever comes first. If these disagree, the error flag is set.
  - On the final beat: wready = 0, go to RESP.
- RESP: bvalid = 1, bid = latched id, bresp = 10 if error flag else 00. awready = 0 and wready = 0.
  - bvalid and bid/bresp hold stable until bready.
  - On bvalid & bready: bvalid = 0, go to IDLE; awready = 1 on the same edge.
- Only one outstanding transaction. No AW/W overlap: W beats arriving before AW are held off (wready = 0).
- beat_cnt is 4 bits; the maximum burst is 16 beats; the counter never wraps within a burst.
- wvalid with wready = 0 has no effect. Simultaneous awvalid in RESP is ignored until IDLE.

Optional Feature:
AXI_WID_CHECK_EN
- Defined: each beat compares wid to the latched awid. On mismatch the beat is suppressed (no mem_we) and the error flag is set; the beat still counts toward burst length.
- Undefined: wid is ignored entirely and no comparison logic is built.

Test Plan:
- INCR: awadr=0x10, awlen=3, awsize=2, awburst=01, four beats with wstrb=F -> mem_we pulses with mem_addr 4,5,6,7 and data in order; bvalid with bid=awid, bresp=00.
- WRAP: awadr=0x38, awlen=3, awsize=2, awburst=10 -> mem_addr 14,15,12,13; bresp=00.
- FIXED: awadr=0x20, awlen=2, awburst=00 -> three writes to mem_addr 8; bresp=00.
- Early wlast: awlen=3, wlast on 2nd beat -> exactly 2 mem_we pulses; bresp=10; awready=1 after the B handshake.
- Backpressure and range: bready held low 5 cycles -> bvalid, bid, bresp stable, awready=0 throughout. Separately, awadr=0x200 (word 128) -> no mem_we, bresp=10.
- Reset mid-burst: aresetn low after beat 1 of a 4-beat burst -> all outputs 0 immediately, no B. After release, a new 1-beat burst completes with bresp=00. With AXI_WID_CHECK_EN, wid != awid -> beat suppressed, bresp=10.
